// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port, with write-ack checking
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          fifo_full,
   input  logic                          fifo_wr_ack,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic                          busy,
   output logic                          wr_err
);
   localparam int OW = $clog2(NUM_REQ);
   typedef enum logic {IDLE, BURST} state_t;
   state_t state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [OW-1:0] own_q, own_d, rr_ptr_q, rr_ptr_d, sel, nxt_own;
   logic [7:0] burst_cnt_q, burst_cnt_d;
   logic [OW:0] idx;
   logic wr_en_q, wr_err_q, wr_err_d;
   always_comb begin
      sel = rr_ptr_q;
      idx = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr_q} + (OW+1)'(k);
         idx = idx >= (OW+1)'(NUM_REQ) ? idx - (OW+1)'(NUM_REQ) : idx;
         if (req[idx[OW-1:0]]) sel = idx[OW-1:0];
      end
   end
   always_comb begin
      fifo_wr_en = ~rst & (state_q == BURST) & req[own_q] & ~fifo_full;
      fifo_data_in = fifo_wr_en ? req_data[own_q*DATA_WIDTH +: DATA_WIDTH] : '0;
      req_ack = fifo_wr_en ? gnt_q : '0;
      nxt_own = own_q == OW'(NUM_REQ-1) ? '0 : own_q + OW'(1);
      state_d = state_q;
      gnt_d = gnt_q;
      own_d = own_q;
      rr_ptr_d = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      if (state_q == IDLE) begin
         if (|req && !fifo_full) begin
            state_d = BURST;
            gnt_d = NUM_REQ'(1) << sel;
            own_d = sel;
            burst_cnt_d = '0;
         end
      end else if (!req[own_q] || (fifo_wr_en && burst_cnt_q == 8'(MAX_BURST-1))) begin
         state_d = IDLE;
         gnt_d = '0;
         rr_ptr_d = nxt_own;
      end else begin
         burst_cnt_d = burst_cnt_q + 8'(fifo_wr_en);
      end
      wr_err_d = wr_err_q | (wr_en_q ^ fifo_wr_ack);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q <= '0;
         own_q <= '0;
         rr_ptr_q <= '0;
         burst_cnt_q <= '0;
         wr_en_q <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q <= gnt_d;
         own_q <= own_d;
         rr_ptr_q <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         wr_en_q <= fifo_wr_en;
         wr_err_q <= wr_err_d;
      end
   end
   assign gnt = gnt_q;
   assign busy = state_q == BURST;
   assign wr_err = wr_err_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
   logic clk = 1'b0, rst = 1'b1, fifo_full = 1'b0, fifo_wr_en, busy, wr_err;
   logic [3:0] req = '0, req_ack, gnt;
   logic [63:0] req_data = '0;
   logic [15:0] fifo_data_in;
   logic ack_q = 1'b0, ack_ovr_en = 1'b0, ack_ovr = 1'b0, fifo_wr_ack;
   logic [3:0] eg;
   logic ew;
   int total = 0, bad = 0, nwr = 0;
   fifo_wr_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4), .MAX_BURST(8)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
      .gnt(gnt), .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack),
      .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .busy(busy), .wr_err(wr_err)
   );
   always #5 clk = ~clk;
   always @(posedge clk) ack_q <= fifo_wr_en;
   assign fifo_wr_ack = ack_ovr_en ? ack_ovr : ack_q;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic set_data(input int c);
      for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = {4'(i+1), 12'(c)};
   endtask
   task automatic do_reset();
      nxt();
      rst = 1'b1; req = '0; fifo_full = 1'b0; ack_ovr_en = 1'b0;
      nxt();
      rst = 1'b0;
   endtask
   initial begin
      req = 4'b0100;
      set_data(7);
      nxt();
      #1;
      chk("rst gnt", gnt, 0);
      chk("rst busy", busy, 0);
      chk("rst wr_err", wr_err, 0);
      chk("rst req_ack", req_ack, 0);
      chk("rst wr_en", fifo_wr_en, 0);
      chk("rst data", fifo_data_in, 0);
      rst = 1'b0;
      for (int c = 0; c <= 21; c++) begin
         if (c > 0) nxt();
         req = c <= 20 ? 4'b0100 : 4'b0000;
         set_data(c);
         #1;
         ew = (c >= 1 && c <= 8) || (c >= 10 && c <= 17) || (c >= 19 && c <= 20);
         nwr += int'(fifo_wr_en);
         chk($sformatf("single wr_en c%0d", c), fifo_wr_en, ew);
         chk($sformatf("single ack c%0d", c), req_ack, ew ? 4'b0100 : 4'b0000);
         if (c <= 20) chk($sformatf("single gnt c%0d", c), gnt, ew ? 4'b0100 : 4'b0000);
         if (ew) chk($sformatf("single data c%0d", c), fifo_data_in, {4'd3, 12'(c)});
      end
      chk("single words", nwr, 18);
      chk("single wr_err", wr_err, 0);
      do_reset();
      for (int c = 0; c <= 45; c++) begin
         if (c > 0) nxt();
         req = 4'b1111;
         set_data(c);
         #1;
         eg = (c % 9 == 0) ? 4'b0000 : 4'b0001 << ((c / 9) % 4);
         chk($sformatf("all gnt c%0d", c), gnt, eg);
         chk($sformatf("all ack c%0d", c), req_ack, eg);
         if (eg != 0) chk($sformatf("all data c%0d", c), fifo_data_in, {4'(((c / 9) % 4) + 1), 12'(c)});
      end
      do_reset();
      for (int c = 0; c <= 14; c++) begin
         if (c > 0) nxt();
         req = 4'b0010;
         fifo_full = c >= 4 && c <= 8;
         set_data(c);
         #1;
         ew = (c >= 1 && c <= 3) || (c >= 9 && c <= 13);
         chk($sformatf("bp wr_en c%0d", c), fifo_wr_en, ew);
         chk($sformatf("bp gnt c%0d", c), gnt, (c >= 1 && c <= 13) ? 4'b0010 : 4'b0000);
         chk($sformatf("bp busy c%0d", c), busy, c >= 1 && c <= 13);
         if (ew) chk($sformatf("bp data c%0d", c), fifo_data_in, {4'd2, 12'(c)});
      end
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         if (c > 0) nxt();
         req = c <= 2 ? 4'b1001 : 4'b1000;
         set_data(c);
         #1;
         eg = (c >= 1 && c <= 3) ? 4'b0001 : (c == 5 ? 4'b1000 : 4'b0000);
         ew = c == 1 || c == 2 || c == 5;
         chk($sformatf("early gnt c%0d", c), gnt, eg);
         chk($sformatf("early ack c%0d", c), req_ack, ew ? eg : 4'b0000);
      end
      do_reset();
      req = 4'b0100;
      nxt();
      chk("fault wr_en", fifo_wr_en, 1);
      nxt();
      ack_ovr_en = 1'b1; ack_ovr = 1'b0;
      #1;
      chk("fault pre", wr_err, 0);
      nxt();
      ack_ovr_en = 1'b0; req = '0;
      chk("fault set", wr_err, 1);
      for (int c = 0; c < 4; c++) nxt();
      chk("fault sticky", wr_err, 1);
      do_reset();
      #1;
      chk("fault cleared", wr_err, 0);
      ack_ovr_en = 1'b1; ack_ovr = 1'b1;
      nxt();
      ack_ovr_en = 1'b0;
      #1;
      chk("spurious ack", wr_err, 1);
      do_reset();
      req = 4'b0100;
      for (int c = 1; c <= 4; c++) begin
         nxt();
         chk($sformatf("mid wr_en c%0d", c), fifo_wr_en, 1);
      end
      nxt();
      rst = 1'b1;
      #1;
      chk("mid rst wr_en", fifo_wr_en, 0);
      chk("mid rst ack", req_ack, 0);
      chk("mid rst data", fifo_data_in, 0);
      nxt();
      rst = 1'b0; req = 4'b1111;
      #1;
      chk("mid gnt", gnt, 0);
      chk("mid busy", busy, 0);
      chk("mid wr_err", wr_err, 0);
      nxt();
      chk("mid regrant", gnt, 4'b0001);
      chk("mid reack", req_ack, 4'b0001);
      chk("mid wr_err2", wr_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
